hc_sr04_range_filter: RTL and testbench
=======================================

Name: hc_sr04_range_filter

Overview:
Downstream stage of the hc_sr04 ranging core. It captures the raw echo tick count when a measurement completes, marked by the falling edge of busy. It converts the count to whole centimetres with a sequential restoring divider, saturates the result and applies a power-of-two moving average. It delivers a filtered distance with a one-cycle valid strobe for display and control logic.

Parameters:
TICKS_PER_CM, 2941, 50 MHz clock ticks per cm of range (58.82 us round trip per cm)
MAX_CM, 400, saturation ceiling in cm
CM_WIDTH, 16, width of the cm outputs
AVG_LOG2, 2, log2 of moving-average depth (depth = 4)

Ports:
clock  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-high reset
range  in  32  raw echo duration in clock ticks from hc_sr04; stable while busy is low
busy  in  1  hc_sr04 busy; 1->0 transition marks a completed measurement
raw_cm  out  CM_WIDTH  latest converted and saturated sample
distance_cm  out  CM_WIDTH  moving-average distance
distance_valid  out  1  one-cycle pulse when raw_cm and distance_cm update
avg_ready  out  1  high once 2^AVG_LOG2 samples are accumulated
out_of_range  out  1  latest sample was clamped to MAX_CM
overrun  out  1  sticky; a completion arrived while a conversion was in progress

Behaviour:
- Clock and reset: one clock domain (busy and range are synchronous to clock). Reset is asynchronous and active-high.
- Reset values: all outputs 0, FSM in IDLE, history buffer, running sum, fill counter and write pointer all 0.
- Edge detect: busy_q is busy registered. Capture cycle C is the cycle with busy_q=1 and busy=0.
- FSM IDLE:
  - on C, latch range into the dividend register and clear the quotient and remainder.
  - go to DIVIDE.
- FSM DIVIDE:
  - 32 cycles of restoring division by TICKS_PER_CM, MSB first, using a 32-bit remainder and a 5-bit step counter.
  - after step 31, go to CLAMP.
- FSM CLAMP (1 cycle):
  - if quotient > MAX_CM: sample = MAX_CM and oor = 1; else sample = quotient[CM_WIDTH-1:0] and oor = 0.
  - go to UPDATE.
- FSM UPDATE (1 cycle):
  - sum <= sum - buf[wp] + sample; buf[wp] <= sample; wp increments mod 2^AVG_LOG2.
  - fill counter saturates at 2^AVG_LOG2.
  - go to OUTPUT.
- FSM OUTPUT (1 cycle):
  - distance_valid = 1; raw_cm = sample; out_of_range = oor.
  - distance_cm = sum >> AVG_LOG2 when the buffer is full, else sample.
  - avg_ready = 1 when the buffer is full.
  - return to IDLE.
- Latency: distance_valid is high exactly 35 cycles after C, i.e. in cycle C+35. Outputs hold between strobes.
- Sum width: CM_WIDTH+AVG_LOG2 bits, which cannot overflow. The shift truncates.
- range = 0 gives sample 0, a valid strobe, and oor = 0.
- Overrun: a capture condition in any state other than IDLE sets overrun (sticky until reset). That sample is discarded and the conversion in progress completes unaffected.
- Reset mid-conversion: the FSM returns to IDLE and no distance_valid is issued for the aborted sample. The first strobe after reset requires a fresh busy falling edge.
- busy held low or held high: no capture. busy rising has no effect.

Decomposition:
- Shared package hc_sr04_pkg: TICKS_PER_CM, the 50 MHz clock constant, MAX_CM, FSM state encoding (IDLE, DIVIDE, CLAMP, UPDATE, OUTPUT).
- One sub-module: hc_sr04_seq_div. It is a 32/32 restoring divider with start/done handshake: start is 1 cycle; done is 1 cycle, 32 cycles after start, with quotient and remainder.
- Averaging and the FSM stay in the top module.

Test Plan:
- range=29410, busy 1->0 -> distance_valid in cycle C+35; raw_cm=10; distance_cm=10 (not yet full); avg_ready=0.
- Boundaries: range=2940 gives raw_cm=0, range=2941 gives raw_cm=1, range=0 gives raw_cm=0; all three with out_of_range=0.
- Four samples of 10, 10, 10, 30 cm (29410 x3, then 88230) -> after the 4th strobe: avg_ready=1, distance_cm=15. A 5th sample of 10 cm -> distance_cm=15; a 6th sample of 10 cm -> distance_cm=15, since buffer {30,10,10,10} sums to 60.
- range=32'hFFFFFFFF -> raw_cm=400, out_of_range=1. The next sample of range=29410 -> out_of_range=0.
- Second busy falling edge 10 cycles after C -> overrun=1. Exactly one strobe, carrying the first value.
- reset pulsed at C+15 -> all outputs 0, no strobe at C+35. A subsequent capture converts normally.

Source files
------------

// File: rtl/hc_sr04_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hc_sr04_pkg
// Description : Shared constants and FSM state encoding for the hc_sr04
//               range post-processing stage.
// Revision    : 1.0 - initial release
// ============================================================================
package hc_sr04_pkg;

    // 50 MHz clock: 58.82 us round trip per cm -> 2941 ticks per cm
    localparam int unsigned CLK_HZ       = 50_000_000;
    localparam int unsigned TICKS_PER_CM = 2941;
    localparam int unsigned MAX_CM       = 400;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DIVIDE = 3'd1,
        ST_CLAMP  = 3'd2,
        ST_UPDATE = 3'd3,
        ST_OUTPUT = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/hc_sr04_seq_div.sv
`default_nettype none
// ============================================================================
// Module      : hc_sr04_seq_div
// Description : 32/32 restoring divider, one quotient bit per cycle, MSB
//               first. A one-cycle start loads the operands; done pulses
//               32 cycles later, in the cycle of the final step, with the
//               final quotient and remainder presented alongside it.
// Revision    : 1.0 - initial release
// ============================================================================
module hc_sr04_seq_div (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [31:0] r_dvd;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [4:0]  r_cnt;
    logic        r_busy;

    // The shifted partial remainder is kept 33 bits wide so a divisor with
    // bit 31 set can never overflow the trial subtraction.
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_ge;
    logic [31:0] w_rem_next;
    logic [31:0] w_quo_next;

    assign w_shift    = {r_rem, r_dvd[31]};
    assign w_ge       = (w_shift >= {1'b0, divisor});
    assign w_diff     = w_shift - {1'b0, divisor};
    assign w_rem_next = w_ge ? w_diff[31:0] : w_shift[31:0];
    assign w_quo_next = {r_quo[30:0], w_ge};

    // The last step's result goes straight out so the consumer can latch it
    // in the same cycle that done is high.
    assign done      = r_busy && (r_cnt == 5'd31);
    assign quotient  = w_quo_next;
    assign remainder = w_rem_next;

    // Load on start, then perform one restoring step per cycle for 32 cycles
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_dvd  <= '0;
            r_rem  <= '0;
            r_quo  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (start) begin
            r_dvd  <= dividend;
            r_rem  <= '0;
            r_quo  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_dvd  <= {r_dvd[30:0], 1'b0};
            r_rem  <= w_rem_next;
            r_quo  <= w_quo_next;
            r_cnt  <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hc_sr04_range_filter.sv
`default_nettype none
// ============================================================================
// Module      : hc_sr04_range_filter
// Description : Captures the hc_sr04 echo tick count on the falling edge of
//               busy, converts it to whole cm, clamps to MAX_CM and runs a
//               2^AVG_LOG2-deep moving average. A one-cycle distance_valid
//               strobe accompanies each new result, 35 cycles after capture.
// Revision    : 1.0 - initial release
// ============================================================================
module hc_sr04_range_filter #(
    parameter int TICKS_PER_CM = hc_sr04_pkg::TICKS_PER_CM,
    parameter int MAX_CM       = hc_sr04_pkg::MAX_CM,
    parameter int CM_WIDTH     = 16,
    parameter int AVG_LOG2     = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [31:0]         range,
    input  logic                busy,
    output logic [CM_WIDTH-1:0] raw_cm,
    output logic [CM_WIDTH-1:0] distance_cm,
    output logic                distance_valid,
    output logic                avg_ready,
    output logic                out_of_range,
    output logic                overrun
);

    import hc_sr04_pkg::*;

    localparam int DEPTH  = 1 << AVG_LOG2;
    localparam int SUM_W  = CM_WIDTH + AVG_LOG2;
    localparam int FILL_W = AVG_LOG2 + 1;

    state_t                r_state;
    logic                  r_busy_q;
    logic [31:0]           r_quotient;
    logic [CM_WIDTH-1:0]   r_sample;
    logic                  r_oor;
    logic [SUM_W-1:0]      r_sum;
    logic [CM_WIDTH-1:0]   r_buf [DEPTH];
    logic [AVG_LOG2-1:0]   r_wp;
    logic [FILL_W-1:0]     r_fill;

    logic                  w_capture;
    logic                  w_div_start;
    logic                  w_div_done;
    logic [31:0]           w_div_quo;
    logic [SUM_W-1:0]      w_sum_next;
    logic                  w_full_next;

    assign w_capture   = r_busy_q && !busy;
    assign w_div_start = (r_state == ST_IDLE) && w_capture;

    // Running sum after the oldest entry is swapped for the new sample; the
    // sum is wide enough to hold DEPTH full-scale samples without overflow.
    assign w_sum_next  = r_sum - SUM_W'(r_buf[r_wp]) + SUM_W'(r_sample);
    assign w_full_next = (r_fill >= FILL_W'(DEPTH - 1));

    // The remainder is of no use here: only whole centimetres are reported.
    hc_sr04_seq_div u_div (
        .clock     (clock),
        .reset     (reset),
        .start     (w_div_start),
        .dividend  (range),
        .divisor   (32'(TICKS_PER_CM)),
        .done      (w_div_done),
        .quotient  (w_div_quo),
        .remainder ()
    );

    // Busy delay register for falling-edge detection
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_busy_q <= 1'b0;
        end else begin
            r_busy_q <= busy;
        end
    end

    // Conversion sequencer, averaging history and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_quotient     <= '0;
            r_sample       <= '0;
            r_oor          <= 1'b0;
            r_sum          <= '0;
            r_wp           <= '0;
            r_fill         <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_buf[i] <= '0;
            end
            raw_cm         <= '0;
            distance_cm    <= '0;
            distance_valid <= 1'b0;
            avg_ready      <= 1'b0;
            out_of_range   <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            distance_valid <= 1'b0;

            // A completion that arrives while busy converting is dropped
            if (w_capture && (r_state != ST_IDLE)) begin
                overrun <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_capture) begin
                        r_state <= ST_DIVIDE;
                    end
                end
                ST_DIVIDE: begin
                    if (w_div_done) begin
                        r_quotient <= w_div_quo;
                        r_state    <= ST_CLAMP;
                    end
                end
                ST_CLAMP: begin
                    if (r_quotient > 32'(MAX_CM)) begin
                        r_sample <= CM_WIDTH'(MAX_CM);
                        r_oor    <= 1'b1;
                    end else begin
                        r_sample <= r_quotient[CM_WIDTH-1:0];
                        r_oor    <= 1'b0;
                    end
                    r_state <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    r_sum       <= w_sum_next;
                    r_buf[r_wp] <= r_sample;
                    r_wp        <= r_wp + 1'b1;
                    if (r_fill != FILL_W'(DEPTH)) begin
                        r_fill <= r_fill + 1'b1;
                    end
                    // Outputs load on this edge so they and the strobe are
                    // visible together during the OUTPUT cycle.
                    distance_valid <= 1'b1;
                    raw_cm         <= r_sample;
                    out_of_range   <= r_oor;
                    avg_ready      <= w_full_next;
                    distance_cm    <= w_full_next ? CM_WIDTH'(w_sum_next >> AVG_LOG2)
                                                  : r_sample;
                    r_state        <= ST_OUTPUT;
                end
                ST_OUTPUT: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hc_sr04_range_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_hc_sr04_range_filter
// Description : Directed self-checking bench for hc_sr04_range_filter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hc_sr04_range_filter;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] range;
    logic        busy;
    logic [15:0] raw_cm;
    logic [15:0] distance_cm;
    logic        distance_valid;
    logic        avg_ready;
    logic        out_of_range;
    logic        overrun;

    int n_checks = 0;
    int n_pass   = 0;

    // Values seen at the first strobe of the latest sample
    int          s_lat;
    int          s_cnt;
    logic [15:0] s_raw;
    logic [15:0] s_dist;
    logic        s_ready;
    logic        s_oor;

    hc_sr04_range_filter dut (
        .clock          (clock),
        .reset          (reset),
        .range          (range),
        .busy           (busy),
        .raw_cm         (raw_cm),
        .distance_cm    (distance_cm),
        .distance_valid (distance_valid),
        .avg_ready      (avg_ready),
        .out_of_range   (out_of_range),
        .overrun        (overrun)
    );

    always #10 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    // mode 0: plain measurement
    // mode 1: second busy falling edge lands in cycle C+10
    // mode 2: reset asserted in cycle C+15
    task automatic run_sample(input logic [31:0] rng, input int mode);
        @(posedge clock); #1;
        busy  = 1'b1;
        range = rng;
        @(posedge clock); #1;
        busy  = 1'b0;          // this cycle is C
        s_lat = -1;
        s_cnt = 0;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clock); #1;  // now in cycle C+k
            if (distance_valid) begin
                if (s_cnt == 0) begin
                    s_lat   = k;
                    s_raw   = raw_cm;
                    s_dist  = distance_cm;
                    s_ready = avg_ready;
                    s_oor   = out_of_range;
                end
                s_cnt++;
            end
            if (mode == 1 && k == 9)  busy  = 1'b1;
            if (mode == 1 && k == 10) busy  = 1'b0;
            if (mode == 2 && k == 15) reset = 1'b1;
            if (mode == 2 && k == 16) reset = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1;
        busy  = 1'b0;
        range = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_raw",     32'(raw_cm),         0);
        check("rst_dist",    32'(distance_cm),    0);
        check("rst_valid",   32'(distance_valid), 0);
        check("rst_ready",   32'(avg_ready),      0);
        check("rst_oor",     32'(out_of_range),   0);
        check("rst_overrun", 32'(overrun),        0);
        reset = 1'b0;

        // First sample: 10 cm, latency and single strobe
        run_sample(32'd29410, 0);
        check("s1_latency", 32'(s_lat),   35);
        check("s1_strobes", 32'(s_cnt),   1);
        check("s1_raw",     32'(s_raw),   10);
        check("s1_dist",    32'(s_dist),  10);
        check("s1_ready",   32'(s_ready), 0);
        check("s1_oor",     32'(s_oor),   0);
        check("s1_hold",    32'(raw_cm),  10);

        // Division boundaries
        run_sample(32'd2940, 0);
        check("b2940_raw", 32'(s_raw), 0);
        check("b2940_oor", 32'(s_oor), 0);
        run_sample(32'd2941, 0);
        check("b2941_raw", 32'(s_raw), 1);
        check("b2941_oor", 32'(s_oor), 0);
        run_sample(32'd0, 0);
        check("b0_strobes", 32'(s_cnt), 1);
        check("b0_raw",     32'(s_raw), 0);
        check("b0_oor",     32'(s_oor), 0);

        // Saturation boundaries
        run_sample(32'd1176400, 0);
        check("c400_raw", 32'(s_raw), 400);
        check("c400_oor", 32'(s_oor), 0);
        run_sample(32'hFFFF_FFFF, 0);
        check("cmax_raw", 32'(s_raw), 400);
        check("cmax_oor", 32'(s_oor), 1);
        run_sample(32'd29410, 0);
        check("cpost_raw", 32'(s_raw), 10);
        check("cpost_oor", 32'(s_oor), 0);

        // Moving average from an empty history
        pulse_reset();
        run_sample(32'd29410, 0);
        run_sample(32'd29410, 0);
        run_sample(32'd29410, 0);
        check("a3_ready", 32'(s_ready), 0);
        check("a3_dist",  32'(s_dist),  10);
        run_sample(32'd88230, 0);
        check("a4_raw",   32'(s_raw),   30);
        check("a4_ready", 32'(s_ready), 1);
        check("a4_dist",  32'(s_dist),  15);
        run_sample(32'd29410, 0);
        check("a5_dist",  32'(s_dist),  15);
        run_sample(32'd29410, 0);
        check("a6_dist",  32'(s_dist),  15);
        run_sample(32'd88230, 0);   // history {10,10,30,30} -> 80/4
        check("a7_dist",  32'(s_dist),  20);
        run_sample(32'd2941, 0);    // history {10,10,30,1} -> 51/4 truncates
        check("a8_dist",  32'(s_dist),  12);
        check("a8_raw",   32'(s_raw),   1);

        // Overrun: second completion during conversion
        check("ov_pre", 32'(overrun), 0);
        run_sample(32'd58820, 1);
        check("ov_strobes", 32'(s_cnt),   1);
        check("ov_raw",     32'(s_raw),   20);
        check("ov_flag",    32'(overrun), 1);
        run_sample(32'd29410, 0);
        check("ov_sticky",  32'(overrun), 1);
        check("ov_next_lat", 32'(s_lat),  35);

        // Reset mid-conversion aborts the sample
        run_sample(32'd29410, 2);
        check("rm_strobes", 32'(s_cnt),       0);
        check("rm_raw",     32'(raw_cm),      0);
        check("rm_dist",    32'(distance_cm), 0);
        check("rm_overrun", 32'(overrun),     0);
        check("rm_ready",   32'(avg_ready),   0);
        run_sample(32'd58820, 0);
        check("rm_next_lat",  32'(s_lat),  35);
        check("rm_next_raw",  32'(s_raw),  20);
        check("rm_next_dist", 32'(s_dist), 20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
